// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with status and sticky error flags
module sync_fifo_param #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 4,
  parameter int AF_TH      = 6,
  parameter int AE_TH      = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       rd_en_i,
  input  logic                       clr_err_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic wr_acc;
  logic rd_acc;

  // Accept decisions use the flags as they stand before the edge; a write
  // into an empty FIFO is never bypassed to the read side.
  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  // Status flags come straight from the registered occupancy.
  assign count_o        = count_q;
  assign full_o         = (count_q == CNT_FULL);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CNT_AF);
  assign almost_empty_o = (count_q <= CNT_AE);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Storage write; slots are deliberately left unreset and never cleared on read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Write pointer advance with explicit wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
    end else if (wr_acc) begin
      wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
  end

  // Read pointer advance with explicit wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
    end else if (rd_acc) begin
      rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous accepted read and write cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en_i && full_o) begin
        overflow_q <= 1'b1;
      end else if (clr_err_i) begin
        overflow_q <= 1'b0;
      end
      if (rd_en_i && empty_o) begin
        underflow_q <= 1'b1;
      end else if (clr_err_i) begin
        underflow_q <= 1'b0;
      end
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Registered read: head is captured on an accepted read, held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          data_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
  end else begin : g_fwft_read
    // Head entry is presented whenever the FIFO holds data; zero otherwise
    // so that data_o reads 0 during reset.
    assign valid_o = ~empty_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  end

endmodule
